d5m_pattern_gen: RTL and testbench
==================================

# d5m_pattern_gen

Synthetic D5M-style pixel source. It drives the same FVAL/LVAL/12-bit data stream that the camera presents to the capture path, which lets the capture → RAW2RGB → SDRAM → VGA chain run on hardware or in simulation without a sensor attached. It generates frames of parameterised geometry and blanking, carries one of four Bayer-domain test patterns, and supports start/stop control that matches the capture block's iSTART/iEND semantics.

## Interface
Parameters:
- H_ACTIVE, default 1280: pixels per line (LVAL high cycles), ≥1
- V_ACTIVE, default 960: lines per frame, ≥1
- H_BLANK, default 64: LVAL-low cycles between lines inside a frame, ≥1
- FV_LEAD, default 16: cycles from FVAL rise to first LVAL rise, ≥1
- FV_TAIL, default 16: cycles from last LVAL fall to FVAL fall, ≥1
- V_BLANK, default 256: FVAL-low cycles between frames, ≥1

Ports:
- iCLK  in  1  pixel clock; everything is on the rising edge
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  level/pulse; starts continuous frame generation when idle
- iEND  in  1  level/pulse; requests a stop at the end of the current frame
- iPATTERN  in  2  00 gradient, 01 red-site, 10 checker, 11 constant
- iLEVEL  in  12  value used by pattern 11
- oDATA  out  12  pixel data; 0 whenever oLVAL=0
- oFVAL  out  1  frame valid
- oLVAL  out  1  line valid
- oX_Cont  out  16  column of the current pixel (valid while oLVAL)
- oY_Cont  out  16  line of the current pixel (valid while oLVAL)
- oFrame_Cont  out  32  completed-frame count
- oBUSY  out  1  high in every state except IDLE

## Operation
- All outputs are registered. Reset values: every output is 0, state is IDLE, and the stop flag is clear.
- States:
  - IDLE → LEAD when iSTART=1 and iEND=0. If both are high in the same cycle, iEND dominates and the block stays IDLE.
  - LEAD: FVAL=1, LVAL=0 for FV_LEAD cycles, then → ACTIVE.
  - ACTIVE: LVAL=1 for H_ACTIVE cycles. oX_Cont runs 0..H_ACTIVE-1. Afterwards → HBLANK if oY_Cont < V_ACTIVE-1, otherwise → TAIL.
  - HBLANK: LVAL=0 for H_BLANK cycles, oY_Cont increments, then → ACTIVE.
  - TAIL: FVAL=1, LVAL=0 for FV_TAIL cycles, then → VBLANK. At the FVAL fall, oFrame_Cont increments (wraps at 2^32).
  - VBLANK: FVAL=0 for V_BLANK cycles. Afterwards → IDLE if the stop flag is set (the flag then clears), otherwise → LEAD.
- Stop handling:
  - iEND=1 in any non-IDLE state sets the stop flag. The current frame always completes, including V_BLANK.
  - iEND in IDLE has no effect.
  - iSTART while busy is ignored.
- iPATTERN is latched at the IDLE/VBLANK → LEAD transition. Changing it mid-frame has no effect until the next frame. iLEVEL is used live.
- Pattern data (x = oX_Cont, y = oY_Cont; Bayer layout: even rows G R G R, odd rows B G B G):
  - 00: (x + y) mod 4096
  - 01: 12'hFFF when y even and x odd (red site), else 0
  - 10: 12'hFFF when x[3] XOR y[3], else 0
  - 11: iLEVEL
- oX_Cont and oY_Cont reset to 0 at each FVAL rise. They hold their last value while LVAL is low, except for the y increment in HBLANK.

## Timing
- If iSTART is high in cycle n (IDLE), oFVAL=1 from cycle n+1, and the first oLVAL=1 is at cycle n+1+FV_LEAD.
- oDATA, oLVAL, oX_Cont and oY_Cont are coincident: the data for pixel (x, y) appears in the same cycle as those counters.
- FVAL high duration = FV_LEAD + V_ACTIVE·H_ACTIVE + (V_ACTIVE-1)·H_BLANK + FV_TAIL.
- Frame period = FVAL high duration + V_BLANK.
- LVAL never rises in the same cycle FVAL rises or falls. There are at least FV_LEAD / FV_TAIL gap cycles.
- oFrame_Cont updates in the first cycle with oFVAL=0.
- oBUSY falls in the cycle after the final V_BLANK cycle of a stopped frame.
- Asynchronous reset mid-frame: outputs go to 0 immediately with no frame completion. After release, the block stays IDLE until the next iSTART.

## Test plan
Small geometry for all scenarios unless noted: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, FV_LEAD=3, FV_TAIL=2, V_BLANK=5.
- Geometry: pulse iSTART once, then iEND in the first frame.
  - Required: FVAL high exactly 21 cycles, 3 LVAL pulses of 4 cycles separated by 2 low cycles, oFrame_Cont 0→1, then oBUSY=0 and no second FVAL.
- Continuous run, iPATTERN=00, no iEND for 3 frames.
  - Required: FVAL rises every 26 cycles.
  - Line 1 data is 1,2,3,4; line 2 data is 2,3,4,5.
  - oFrame_Cont=3 after the third FVAL fall.
- Pattern 01 and 10 checks.
  - With iPATTERN=01: line 0 data is 0,FFF,0,FFF and line 1 is all 0.
  - With H_ACTIVE=16, V_ACTIVE=9, iPATTERN=10: pixels (8,0) and (0,8) are FFF, and pixels (0,0) and (8,8) are 0.
- Pattern latching: change iPATTERN from 11 (iLEVEL=12'h5A5) to 00 mid-frame.
  - Required: the rest of that frame stays 5A5 and the next frame is a gradient.
  - iLEVEL changed mid-line is reflected in the next cycle.
- Control corner cases:
  - iSTART and iEND together in IDLE → no FVAL.
  - iSTART during LEAD → no effect.
  - iEND asserted during V_BLANK of frame k → frame k+1 is not started.
- Asynchronous reset during ACTIVE (second line).
  - Required: all outputs 0 in the same cycle and oFrame_Cont=0.
  - After release, no activity until iSTART; then a full 21-cycle FVAL frame.

Source files
------------

// File: rtl/d5m_pattern_gen.sv
// Synthetic D5M pixel source: FVAL/LVAL/12-bit Bayer test patterns with
// parameterised geometry and blanking, plus start / stop-at-frame-end control.
module d5m_pattern_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 960,
  parameter int unsigned H_BLANK  = 64,
  parameter int unsigned FV_LEAD  = 16,
  parameter int unsigned FV_TAIL  = 16,
  parameter int unsigned V_BLANK  = 256
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iEND,
  input  logic [1:0]  iPATTERN,
  input  logic [11:0] iLEVEL,
  output logic [11:0] oDATA,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oBUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_ACTIVE, S_HBLANK, S_TAIL, S_VBLANK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_x, w_x_nxt;
  logic [15:0] r_y, w_y_nxt;
  logic [31:0] r_frame, w_frame_nxt;
  logic        r_stop, w_stop_nxt, w_stop_req;
  logic [1:0]  r_pat, w_pat_nxt;
  logic [11:0] r_data, w_data_nxt;
  logic        r_fval, w_fval_nxt;
  logic        r_lval, w_lval_nxt;
  logic        r_busy, w_busy_nxt;

  // Next-state, counters and pattern selection; outputs are computed from the
  // next state so that every output is a flop yet coincides with its state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 32'd1;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_frame_nxt = r_frame;
    w_pat_nxt   = r_pat;
    w_stop_req  = r_stop | iEND;
    w_stop_nxt  = (r_state == S_IDLE) ? 1'b0 : w_stop_req;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (iSTART && !iEND) begin
          w_state_nxt = S_LEAD;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_pat_nxt   = iPATTERN;
        end
      end
      S_LEAD: begin
        if (r_cnt == FV_LEAD - 1) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
          w_x_nxt     = '0;
        end
      end
      S_ACTIVE: begin
        w_cnt_nxt = '0;
        if (r_x == 16'(H_ACTIVE - 1)) begin
          if (r_y < 16'(V_ACTIVE - 1)) w_state_nxt = S_HBLANK;
          else                         w_state_nxt = S_TAIL;
        end else begin
          w_x_nxt = r_x + 16'd1;
        end
      end
      S_HBLANK: begin
        if (r_cnt == H_BLANK - 1) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
          w_x_nxt     = '0;
          w_y_nxt     = r_y + 16'd1;
        end
      end
      S_TAIL: begin
        if (r_cnt == FV_TAIL - 1) begin
          w_state_nxt = S_VBLANK;
          w_cnt_nxt   = '0;
          w_frame_nxt = r_frame + 32'd1;
        end
      end
      S_VBLANK: begin
        if (r_cnt == V_BLANK - 1) begin
          w_cnt_nxt = '0;
          if (w_stop_req) begin
            w_state_nxt = S_IDLE;
            w_stop_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_LEAD;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_pat_nxt   = iPATTERN;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_fval_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_VBLANK);
    w_lval_nxt = (w_state_nxt == S_ACTIVE);
    w_busy_nxt = (w_state_nxt != S_IDLE);

    w_data_nxt = '0;
    if (w_lval_nxt) begin
      case (w_pat_nxt)
        2'b00:   w_data_nxt = w_x_nxt[11:0] + w_y_nxt[11:0];
        2'b01:   w_data_nxt = (w_x_nxt[0] && !w_y_nxt[0]) ? 12'hFFF : 12'h000;
        2'b10:   w_data_nxt = (w_x_nxt[3] ^ w_y_nxt[3]) ? 12'hFFF : 12'h000;
        default: w_data_nxt = iLEVEL;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
      r_stop  <= 1'b0;
      r_pat   <= '0;
      r_data  <= '0;
      r_fval  <= 1'b0;
      r_lval  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_frame <= w_frame_nxt;
      r_stop  <= w_stop_nxt;
      r_pat   <= w_pat_nxt;
      r_data  <= w_data_nxt;
      r_fval  <= w_fval_nxt;
      r_lval  <= w_lval_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign oDATA       = r_data;
  assign oFVAL       = r_fval;
  assign oLVAL       = r_lval;
  assign oX_Cont     = r_x;
  assign oY_Cont     = r_y;
  assign oFrame_Cont = r_frame;
  assign oBUSY       = r_busy;

endmodule

// File: tb/tb_d5m_pattern_gen.sv
// Scoreboard bench for d5m_pattern_gen: stimulus queues expected pixels,
// a monitor pops and compares on every LVAL cycle and records frame timing.
module tb_d5m_pattern_gen;

  logic        clk;
  logic        rst, start, endr;
  logic [1:0]  pat;
  logic [11:0] lvl;
  logic [11:0] oDATA;
  logic        oFVAL, oLVAL, oBUSY;
  logic [15:0] oX_Cont, oY_Cont;
  logic [31:0] oFrame_Cont;

  logic        rst2, start2, end2;
  logic [11:0] oDATA2;
  logic        oFVAL2, oLVAL2, oBUSY2;
  logic [15:0] oX2, oY2;
  logic [31:0] oFrame2;

  d5m_pattern_gen #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .FV_LEAD(3), .FV_TAIL(2), .V_BLANK(5)
  ) u_dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iEND(endr), .iPATTERN(pat), .iLEVEL(lvl),
    .oDATA(oDATA), .oFVAL(oFVAL), .oLVAL(oLVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
    .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY)
  );

  d5m_pattern_gen #(
    .H_ACTIVE(16), .V_ACTIVE(9), .H_BLANK(2), .FV_LEAD(3), .FV_TAIL(2), .V_BLANK(5)
  ) u_dut2 (
    .iCLK(clk), .iRST(rst2), .iSTART(start2), .iEND(end2), .iPATTERN(2'b10), .iLEVEL(12'h000),
    .oDATA(oDATA2), .oFVAL(oFVAL2), .oLVAL(oLVAL2), .oX_Cont(oX2), .oY_Cont(oY2),
    .oFrame_Cont(oFrame2), .oBUSY(oBUSY2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_total++;
    $display("FAIL %s: wait budget expired (got none, expected event)", nm);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [11:0] d;
  } pix_t;
  pix_t sb_q[$];

  logic [11:0] t_grad[12] = '{12'h000, 12'h001, 12'h002, 12'h003,
                              12'h001, 12'h002, 12'h003, 12'h004,
                              12'h002, 12'h003, 12'h004, 12'h005};
  logic [11:0] t_red[12]  = '{12'h000, 12'hFFF, 12'h000, 12'hFFF,
                              12'h000, 12'h000, 12'h000, 12'h000,
                              12'h000, 12'hFFF, 12'h000, 12'hFFF};
  logic [11:0] t_5a5[12]  = '{12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5,
                              12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5,
                              12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5};
  logic [11:0] t_mix[12]  = '{12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5,
                              12'h5A5, 12'h5A5, 12'h123, 12'h123,
                              12'h123, 12'h123, 12'h123, 12'h123};

  logic [15:0] c_x[4] = '{16'd8, 16'd0, 16'd0, 16'd8};
  logic [15:0] c_y[4] = '{16'd0, 16'd8, 16'd0, 16'd8};
  logic [11:0] c_d[4] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000};
  int hits2 = 0;

  task automatic push_pix(input logic [15:0] x, input logic [15:0] y, input logic [11:0] d);
    pix_t p;
    p.x = x; p.y = y; p.d = d;
    sb_q.push_back(p);
  endtask

  task automatic push_tbl(input logic [11:0] t[12]);
    for (int i = 0; i < 12; i++) push_pix(16'(i % 4), 16'(i / 4), t[i]);
  endtask

  // Monitor state, updated one time unit after each rising edge.
  int cyc = 0;
  int m_rises = 0, m_falls = 0;
  int m_rise_cyc = 0, m_fall_cyc = 0, m_period = 0, m_flen = 0;
  int m_lead = 0, m_busy_fall_cyc = 0;
  int m_lrise_cyc = 0, m_lfall_cyc = 0;
  bit m_lead_seen = 0, m_lfell = 0;
  int len_q[$];
  int gap_q[$];
  logic p_fval = 0, p_lval = 0, p_busy = 0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      if (oFVAL && !p_fval) begin
        m_rises++;
        if (m_rises > 1) m_period = cyc - m_rise_cyc;
        m_rise_cyc  = cyc;
        m_lead_seen = 0;
        m_lfell     = 0;
      end
      if (!oFVAL && p_fval) begin
        m_falls++;
        m_fall_cyc = cyc;
        m_flen     = cyc - m_rise_cyc;
        chk("lval_low_before_fval_fall", 64'(p_lval), 64'd0);
      end
      if (oLVAL && !p_lval) begin
        chk("lval_rise_inside_fval", 64'({p_fval, oFVAL}), 64'd3);
        if (!m_lead_seen) begin
          m_lead      = cyc - m_rise_cyc;
          m_lead_seen = 1;
        end
        if (m_lfell) gap_q.push_back(cyc - m_lfall_cyc);
        m_lrise_cyc = cyc;
      end
      if (!oLVAL && p_lval) begin
        len_q.push_back(cyc - m_lrise_cyc);
        m_lfell     = 1;
        m_lfall_cyc = cyc;
      end
      if (!oBUSY && p_busy) m_busy_fall_cyc = cyc;
      if (oLVAL) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL pixel_unexpected: got x=%0d y=%0d d=%0h expected no pixel",
                   oX_Cont, oY_Cont, oDATA);
        end else begin
          pix_t e;
          e = sb_q.pop_front();
          chk("pixel", 64'({oY_Cont, oX_Cont, oDATA}), 64'({e.y, e.x, e.d}));
        end
      end else begin
        chk("data_zero_when_blank", 64'(oDATA), 64'd0);
      end
    end
    p_fval = oFVAL;
    p_lval = oLVAL;
    p_busy = oBUSY;
  end

  // Checker-pattern probe on the larger instance.
  always begin
    @(posedge clk);
    #1;
    if (!rst2 && oLVAL2) begin
      for (int i = 0; i < 4; i++) begin
        if (oX2 == c_x[i] && oY2 == c_y[i]) begin
          chk("checker_pixel", 64'(oDATA2), 64'(c_d[i]));
          hits2++;
        end
      end
    end
  end

  task automatic clear_mon();
    m_rises = 0; m_falls = 0; m_lfell = 0; m_lead_seen = 0;
    len_q.delete();
    gap_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    clear_mon();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_end();
    endr = 1'b1;
    @(negedge clk) endr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (oBUSY && k < budget) begin @(negedge clk); k++; end
    if (oBUSY) timeout(nm);
  endtask

  task automatic wait_rises(input int n, input int budget, input string nm);
    int k = 0;
    while (m_rises < n && k < budget) begin @(negedge clk); k++; end
    if (m_rises < n) timeout(nm);
  endtask

  task automatic wait_falls(input int n, input int budget, input string nm);
    int k = 0;
    while (m_falls < n && k < budget) begin @(negedge clk); k++; end
    if (m_falls < n) timeout(nm);
  endtask

  task automatic wait_pix(input logic [15:0] x, input logic [15:0] y, input int budget,
                          input string nm);
    int k = 0;
    while (!(oLVAL && oX_Cont == x && oY_Cont == y) && k < budget) begin
      @(negedge clk); k++;
    end
    if (!(oLVAL && oX_Cont == x && oY_Cont == y)) timeout(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; endr = 1'b0; pat = 2'b00; lvl = 12'h000;
    rst2 = 1'b1; start2 = 1'b0; end2 = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_fval", 64'(oFVAL), 64'd0);
    chk("reset_lval", 64'(oLVAL), 64'd0);
    chk("reset_data", 64'(oDATA), 64'd0);
    chk("reset_x", 64'(oX_Cont), 64'd0);
    chk("reset_y", 64'(oY_Cont), 64'd0);
    chk("reset_frame", 64'(oFrame_Cont), 64'd0);
    chk("reset_busy", 64'(oBUSY), 64'd0);
    rst = 1'b0;
    rst2 = 1'b0;
    clear_mon();

    // Single frame geometry with stop requested inside it.
    pat = 2'b00;
    push_tbl(t_grad);
    pulse_start();
    chk("fval_cycle_after_start", 64'(oFVAL), 64'd1);
    pulse_end();
    wait_idle(100, "geom_idle");
    chk("geom_fval_len", 64'(m_flen), 64'd21);
    chk("geom_lead_gap", 64'(m_lead), 64'd3);
    chk("geom_lval_count", 64'(len_q.size()), 64'd3);
    foreach (len_q[i]) chk("geom_lval_len", 64'(len_q[i]), 64'd4);
    chk("geom_gap_count", 64'(gap_q.size()), 64'd2);
    foreach (gap_q[i]) chk("geom_lval_gap", 64'(gap_q[i]), 64'd2);
    chk("geom_frame_cont", 64'(oFrame_Cont), 64'd1);
    chk("geom_busy_after_vblank", 64'(m_busy_fall_cyc - m_fall_cyc), 64'd5);
    repeat (40) @(negedge clk);
    chk("geom_no_second_frame", 64'(m_rises), 64'd1);
    chk("geom_sb_drained", 64'(sb_q.size()), 64'd0);

    // Continuous gradient, then stop requested in V_BLANK of frame 3.
    do_reset();
    pat = 2'b00;
    push_tbl(t_grad); push_tbl(t_grad); push_tbl(t_grad);
    pulse_start();
    wait_rises(2, 100, "cont_rise2");
    chk("cont_period_1", 64'(m_period), 64'd26);
    wait_rises(3, 100, "cont_rise3");
    chk("cont_period_2", 64'(m_period), 64'd26);
    wait_falls(3, 100, "cont_fall3");
    chk("cont_frame_cont", 64'(oFrame_Cont), 64'd3);
    chk("cont_fval_len", 64'(m_flen), 64'd21);
    pulse_end();
    wait_idle(100, "cont_idle");
    repeat (40) @(negedge clk);
    chk("vblank_end_blocks_next", 64'(m_rises), 64'd3);
    chk("cont_sb_drained", 64'(sb_q.size()), 64'd0);

    // Red-site pattern.
    do_reset();
    pat = 2'b01;
    push_tbl(t_red);
    pulse_start();
    pulse_end();
    wait_idle(100, "red_idle");
    chk("red_sb_drained", 64'(sb_q.size()), 64'd0);

    // Pattern latching and live iLEVEL.
    do_reset();
    pat = 2'b11; lvl = 12'h5A5;
    push_tbl(t_5a5); push_tbl(t_grad); push_tbl(t_mix);
    pulse_start();
    wait_pix(16'd0, 16'd0, 100, "latch_first_pixel");
    pat = 2'b00;
    wait_rises(2, 100, "latch_rise2");
    wait_pix(16'd0, 16'd0, 100, "latch_f2_pixel");
    pat = 2'b11;
    wait_rises(3, 100, "latch_rise3");
    wait_pix(16'd1, 16'd1, 100, "latch_f3_pixel11");
    lvl = 12'h123;
    pulse_end();
    wait_idle(100, "latch_idle");
    chk("latch_sb_drained", 64'(sb_q.size()), 64'd0);
    lvl = 12'h000;

    // Control corner cases.
    do_reset();
    @(negedge clk) begin start = 1'b1; endr = 1'b1; end
    @(negedge clk) begin start = 1'b0; endr = 1'b0; end
    repeat (10) @(negedge clk);
    chk("start_end_idle_no_fval", 64'(m_rises), 64'd0);
    chk("start_end_idle_busy", 64'(oBUSY), 64'd0);
    pat = 2'b00;
    push_tbl(t_grad);
    pulse_start();
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    pulse_end();
    wait_idle(100, "ctrl_idle");
    chk("start_in_lead_fval_len", 64'(m_flen), 64'd21);
    chk("start_in_lead_lead_gap", 64'(m_lead), 64'd3);
    chk("start_in_lead_one_frame", 64'(m_rises), 64'd1);
    chk("ctrl_sb_drained", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset during the second line.
    do_reset();
    pat = 2'b00;
    for (int i = 0; i < 6; i++) push_pix(16'(i % 4), 16'(i / 4), t_grad[i]);
    pulse_start();
    wait_pix(16'd1, 16'd1, 100, "areset_pixel11");
    #2 rst = 1'b1;
    #1;
    chk("areset_fval", 64'(oFVAL), 64'd0);
    chk("areset_lval", 64'(oLVAL), 64'd0);
    chk("areset_data", 64'(oDATA), 64'd0);
    chk("areset_x", 64'(oX_Cont), 64'd0);
    chk("areset_y", 64'(oY_Cont), 64'd0);
    chk("areset_frame", 64'(oFrame_Cont), 64'd0);
    chk("areset_busy", 64'(oBUSY), 64'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    clear_mon();
    repeat (10) @(negedge clk);
    chk("areset_stays_idle", 64'(m_rises), 64'd0);
    chk("areset_idle_busy", 64'(oBUSY), 64'd0);
    chk("areset_sb_drained", 64'(sb_q.size()), 64'd0);
    push_tbl(t_grad);
    pulse_start();
    pulse_end();
    wait_idle(100, "areset_restart_idle");
    chk("areset_restart_fval_len", 64'(m_flen), 64'd21);
    chk("areset_restart_frame", 64'(oFrame_Cont), 64'd1);
    chk("areset_restart_sb_drained", 64'(sb_q.size()), 64'd0);

    // Checker pattern on 16x9 geometry.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) begin start2 = 1'b0; end2 = 1'b1; end
    @(negedge clk) end2 = 1'b0;
    begin
      int k = 0;
      while (oBUSY2 && k < 400) begin @(negedge clk); k++; end
      if (oBUSY2) timeout("checker_idle");
    end
    chk("checker_hits", 64'(hits2), 64'd4);
    chk("checker_frame_cont", 64'(oFrame2), 64'd1);
    chk("checker_fval_low", 64'(oFVAL2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
